// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external 16-bit memory bus between the CPU
// port (0, fixed priority) and the DMA/loader port (1). DMA is protected from
// starvation by a counter of back-to-back CPU wins. Each access runs as
// grant -> strobe phase (WAIT_STATES+1 cycles) -> one-cycle acknowledge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | bus free, arbitrate every cycle
// S_ACCESS | strobes on pins, wait counter running down to zero
// S_ACK    | ACKn pulsed for the owner, GNT still shows the owner
module mem_bus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int MAX_STARVE  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic        BYTE0,
    input  logic        BYTE1,
    input  logic [15:0] ADDR0,
    input  logic [15:0] ADDR1,
    input  logic [15:0] WDATA0,
    input  logic [15:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [15:0] RDATA0,
    output logic [15:0] RDATA1,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_DOUT,
    input  logic [15:0] MEM_DIN,
    output logic        MEM_RD,
    output logic        MEM_WR0,
    output logic        MEM_WR1,
    output logic [1:0]  GNT
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);

    state_t      state, state_nx;
    logic [3:0]  wait_cnt, wait_nx;
    logic [7:0]  starve_cnt, starve_nx;
    logic        owner, owner_nx;
    logic        lat_we, lat_we_nx;
    logic        lat_byte, lat_byte_nx;
    logic [1:0]  gnt_nx;
    logic        ack0_nx, ack1_nx;
    logic        rd_nx, wr0_nx, wr1_nx;
    logic [15:0] addr_nx, dout_nx, rdata0_nx, rdata1_nx;

    logic        pick1, sel_we, sel_byte;
    logic [15:0] sel_addr, sel_wdata, rd_word;

    // Winner selection and the winner's request fields, plus read-lane steering.
    always_comb begin
        pick1     = REQ1 && ((starve_cnt == STARVE_LIM) || !REQ0);
        sel_we    = pick1 ? WE1    : WE0;
        sel_byte  = pick1 ? BYTE1  : BYTE0;
        sel_addr  = pick1 ? ADDR1  : ADDR0;
        sel_wdata = pick1 ? WDATA1 : WDATA0;
        if (!lat_byte)
            rd_word = MEM_DIN;
        else if (MEM_ADDR[0])
            rd_word = {8'h00, MEM_DIN[15:8]};
        else
            rd_word = {8'h00, MEM_DIN[7:0]};
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        starve_nx   = starve_cnt;
        owner_nx    = owner;
        lat_we_nx   = lat_we;
        lat_byte_nx = lat_byte;
        gnt_nx      = GNT;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;
        rd_nx       = MEM_RD;
        wr0_nx      = MEM_WR0;
        wr1_nx      = MEM_WR1;
        addr_nx     = MEM_ADDR;
        dout_nx     = MEM_DOUT;
        rdata0_nx   = RDATA0;
        rdata1_nx   = RDATA1;

        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    owner_nx    = pick1;
                    lat_we_nx   = sel_we;
                    lat_byte_nx = sel_byte;
                    gnt_nx      = pick1 ? 2'b10 : 2'b01;
                    wait_nx     = WAIT_LOAD;
                    addr_nx     = sel_addr;
                    rd_nx       = !sel_we;
                    wr0_nx      = sel_we && (!sel_byte || !sel_addr[0]);
                    wr1_nx      = sel_we && (!sel_byte || sel_addr[0]);
                    if (!sel_byte)
                        dout_nx = sel_wdata;
                    else if (sel_addr[0])
                        dout_nx = {sel_wdata[7:0], 8'h00};
                    else
                        dout_nx = {8'h00, sel_wdata[7:0]};
                    state_nx    = S_ACCESS;
                end
                if (pick1 || !REQ1)
                    starve_nx = 8'd0;
                else if (starve_cnt != STARVE_LIM)
                    starve_nx = starve_cnt + 8'd1;
            end
            S_ACCESS: begin
                if (wait_cnt != 4'd0) begin
                    wait_nx = wait_cnt - 4'd1;
                end else begin
                    rd_nx  = 1'b0;
                    wr0_nx = 1'b0;
                    wr1_nx = 1'b0;
                    if (!lat_we) begin
                        if (owner)
                            rdata1_nx = rd_word;
                        else
                            rdata0_nx = rd_word;
                    end
                    ack0_nx  = !owner;
                    ack1_nx  = owner;
                    state_nx = S_ACK;
                end
            end
            S_ACK: begin
                gnt_nx   = 2'b00;
                state_nx = S_IDLE;
            end
            default: begin
                gnt_nx   = 2'b00;
                rd_nx    = 1'b0;
                wr0_nx   = 1'b0;
                wr1_nx   = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-access
    // simply abandons the transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            starve_cnt <= 8'd0;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_byte   <= 1'b0;
            GNT        <= 2'b00;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            MEM_RD     <= 1'b0;
            MEM_WR0    <= 1'b0;
            MEM_WR1    <= 1'b0;
            MEM_ADDR   <= 16'h0000;
            MEM_DOUT   <= 16'h0000;
            RDATA0     <= 16'h0000;
            RDATA1     <= 16'h0000;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_nx;
            starve_cnt <= starve_nx;
            owner      <= owner_nx;
            lat_we     <= lat_we_nx;
            lat_byte   <= lat_byte_nx;
            GNT        <= gnt_nx;
            ACK0       <= ack0_nx;
            ACK1       <= ack1_nx;
            MEM_RD     <= rd_nx;
            MEM_WR0    <= wr0_nx;
            MEM_WR1    <= wr1_nx;
            MEM_ADDR   <= addr_nx;
            MEM_DOUT   <= dout_nx;
            RDATA0     <= rdata0_nx;
            RDATA1     <= rdata1_nx;
        end
    end

endmodule
